// File: rtl/mem_mfc_ram_pkg.sv
// Shared types and constants for the MFC-handshaked main memory.
// Holds default widths, read/write encoding and the controller state encoding.
package mem_mfc_ram_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Wait counter width; a zero-wait build still needs a 1-bit counter to exist.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_mfc_ram_if.sv
// Request/completion bus between the load/store FSM (master) and main memory (slave).
interface mem_mfc_ram_if
  import mem_mfc_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              mem_EN;
  logic              mem_RW;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              MFC;
  logic              busy;

  modport master (
    output mem_EN, mem_RW, addr, data_in,
    input  data_out, MFC, busy
  );

  modport slave (
    input  mem_EN, mem_RW, addr, data_in,
    output data_out, MFC, busy
  );

endinterface

// File: rtl/mem_mfc_ram_sp_ram.sv
// Single-port synchronous RAM with registered read data.
module sp_ram #(
  parameter int    DATA_W    = 16,
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  // Read register clears on reset; the array itself is never cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     dout <= '0;
    else if (re) dout <= mem[addr];
  end

endmodule

// File: rtl/mem_mfc_ram.sv
// Main memory controller: latches a request, waits WAIT_CYCLES, commits to the RAM,
// then holds MFC until the requester drops mem_EN (4-phase handshake).
module mem_mfc_ram
  import mem_mfc_ram_pkg::*;
#(
  parameter int    DATA_W      = DATA_W_DEF,
  parameter int    ADDR_W      = ADDR_W_DEF,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic           clk,
  input  logic           rst,
  mem_mfc_ram_if.slave   bus
);

  localparam int CNT_W = cnt_width(WAIT_CYCLES);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              mfc_q;
  logic              busy_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              rw_q;
  logic              commit;
  logic              ram_we;
  logic              ram_re;

  // Commit only while the requester still holds mem_EN; a drop in WAIT is an abort.
  assign commit = (state == ST_WAIT) && bus.mem_EN && (cnt == '0);
  assign ram_we = commit && (rw_q == RW_WRITE);
  assign ram_re = commit && (rw_q == RW_READ);

  assign bus.MFC  = mfc_q;
  assign bus.busy = busy_q;

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && bus.mem_EN) begin
      addr_q <= bus.addr;
      data_q <= bus.data_in;
      rw_q   <= bus.mem_RW;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mfc_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.mem_EN) begin
            cnt    <= CNT_W'(WAIT_CYCLES);
            state  <= ST_WAIT;
            busy_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (!bus.mem_EN) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= ST_ACK;
            mfc_q <= 1'b1;
          end
        end
        ST_ACK: begin
          if (!bus.mem_EN) begin
            state  <= ST_IDLE;
            mfc_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          mfc_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  sp_ram #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .re   (ram_re),
    .addr (addr_q),
    .din  (data_q),
    .dout (bus.data_out)
  );

endmodule
